// File: rtl/clock_pkg.sv
// Shared types and constants for the programmable clock divider.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PARK = 2'd2
    } clkdiv_state_t;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clock_divider_tick_counter.sv
// Free-running wrap counter of TICK strobes; all-ones rolls over to zero.
module tick_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/clock_divider.sv
// Glitch-free runtime-programmable clock divider with TICK strobe and period count.
// Output period is N cycles: high for N>>1, low for the remainder.
module clock_divider
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [WIDTH-1:0]     DIV_IN,
    input  logic                 DIV_LOAD,
    output logic                 DIV_BUSY,
    output logic                 CLOCK_OUT,
    output logic                 TICK,
    output logic [CNT_WIDTH-1:0] TICK_COUNT
);

    clkdiv_state_t    state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] din_clamped;
    logic             wrap;
    logic             high_next;
    logic             apply;

    assign half        = n_q >> 1;
    assign cnt_inc     = cnt_q + WIDTH'(1);
    assign wrap        = (cnt_q == (n_q - WIDTH'(1)));
    assign high_next   = (cnt_inc < half);
    assign din_clamped = (DIV_IN < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : DIV_IN;

    // State and datapath registers
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= WIDTH'(DEFAULT_DIV);
            pend_q  <= WIDTH'(DEFAULT_DIV);
            busy_q  <= 1'b0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state: stopping during a high phase parks until that phase has finished
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ENABLE) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!ENABLE) begin
                    state_d = (out_q && high_next) ? PARK : IDLE;
                end
            end
            PARK: begin
                if (ENABLE) begin
                    state_d = RUN;
                end else if (!high_next) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs, period counter and pending-ratio handling
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        tick_d = 1'b0;
        n_d    = n_q;
        pend_d = pend_q;
        busy_d = busy_q;
        apply  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                out_d  = ENABLE;
                tick_d = ENABLE;
            end
            RUN, PARK: begin
                if (state_d == IDLE) begin
                    cnt_d = '0;
                    out_d = 1'b0;
                end else if (state_q == RUN && wrap) begin
                    cnt_d  = '0;
                    out_d  = 1'b1;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    out_d = high_next;
                end
            end
            default: begin
                cnt_d = '0;
                out_d = 1'b0;
            end
        endcase

        // A new ratio only takes effect on a period boundary or while stopped
        apply = busy_q && ((state_q == IDLE) || (state_d == IDLE) ||
                           (state_q == RUN && state_d == RUN && wrap));

        if (apply) begin
            n_d    = pend_q;
            busy_d = 1'b0;
        end else if (DIV_LOAD && !busy_q) begin
            pend_d = din_clamped;
            busy_d = 1'b1;
        end
    end

    tick_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_tick_counter (
        .clk_i  (CLOCK),
        .rst_i  (RESET),
        .inc_i  (tick_d),
        .count_o(TICK_COUNT)
    );

    assign DIV_BUSY  = busy_q;
    assign CLOCK_OUT = out_q;
    assign TICK      = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed vector bench for clock_divider: table of per-cycle expectations plus
// hand-written sequences for asynchronous reset and TICK_COUNT rollover.
module tb_clock_divider;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_busy;
    logic             clock_out;
    logic             tick;
    logic [CW-1:0]    tick_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             en;
        logic             ld;
        logic [WIDTH-1:0] din;
        logic             out;
        logic             tk;
        logic             busy;
        logic [CW-1:0]    cnt;
    } vec_t;

    vec_t vecs[$];

    clock_divider #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(4),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .ENABLE    (enable),
        .DIV_IN    (div_in),
        .DIV_LOAD  (div_load),
        .DIV_BUSY  (div_busy),
        .CLOCK_OUT (clock_out),
        .TICK      (tick),
        .TICK_COUNT(tick_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic ld, input logic [WIDTH-1:0] din,
                       input logic out, input logic tk, input logic busy,
                       input logic [CW-1:0] cnt);
        vec_t v;
        v.en = en; v.ld = ld; v.din = din;
        v.out = out; v.tk = tk; v.busy = busy; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic fill_table();
        // N=4 from reset, enable one cycle in
        add(0,0,0, 0,0,0,0);
        add(1,0,0, 1,1,0,1); add(1,0,0, 1,0,0,1); add(1,0,0, 0,0,0,1); add(1,0,0, 0,0,0,1);
        add(1,0,0, 1,1,0,2); add(1,0,0, 1,0,0,2); add(1,0,0, 0,0,0,2); add(1,0,0, 0,0,0,2);
        add(1,0,0, 1,1,0,3); add(1,0,0, 1,0,0,3); add(1,0,0, 0,0,0,3); add(1,0,0, 0,0,0,3);
        // load 6 mid-period; second load of 8 while busy is dropped
        add(1,0,0, 1,1,0,4); add(1,1,6, 1,0,1,4); add(1,1,8, 0,0,1,4); add(1,0,0, 0,0,1,4);
        add(1,0,0, 1,1,0,5); add(1,0,0, 1,0,0,5); add(1,0,0, 1,0,0,5);
        add(1,0,0, 0,0,0,5); add(1,0,0, 0,0,0,5); add(1,0,0, 0,0,0,5);
        add(1,0,0, 1,1,0,6);
        // switch to N=3
        add(1,1,3, 1,0,1,6); add(1,0,0, 1,0,1,6);
        add(1,0,0, 0,0,1,6); add(1,0,0, 0,0,1,6); add(1,0,0, 0,0,1,6);
        add(1,0,0, 1,1,0,7); add(1,0,0, 0,0,0,7); add(1,0,0, 0,0,0,7);
        add(1,0,0, 1,1,0,8); add(1,0,0, 0,0,0,8); add(1,0,0, 0,0,0,8);
        add(1,0,0, 1,1,0,9);
        // switch to N=2
        add(1,1,2, 0,0,1,9); add(1,0,0, 0,0,1,9);
        add(1,0,0, 1,1,0,10); add(1,0,0, 0,0,0,10); add(1,0,0, 1,1,0,11);
        add(1,0,0, 0,0,0,11); add(1,0,0, 1,1,0,12);
        // switch to N=8
        add(1,1,8, 0,0,1,12); add(1,0,0, 1,1,0,13);
        add(1,0,0, 1,0,0,13); add(1,0,0, 1,0,0,13); add(1,0,0, 1,0,0,13);
        add(1,0,0, 0,0,0,13); add(1,0,0, 0,0,0,13); add(1,0,0, 0,0,0,13); add(1,0,0, 0,0,0,13);
        add(1,0,0, 1,1,0,14);
        // stop in first high cycle: high still lasts four cycles
        add(0,0,0, 1,0,0,14); add(0,0,0, 1,0,0,14); add(0,0,0, 1,0,0,14);
        add(0,0,0, 0,0,0,14); add(0,0,0, 0,0,0,14); add(0,0,0, 0,0,0,14);
        // re-enable, then stop in the low phase
        add(1,0,0, 1,1,0,15); add(1,0,0, 1,0,0,15); add(1,0,0, 1,0,0,15); add(1,0,0, 1,0,0,15);
        add(1,0,0, 0,0,0,15);
        add(0,0,0, 0,0,0,15); add(0,0,0, 0,0,0,15); add(0,0,0, 0,0,0,15);
        // park then resume without disturbing the phase
        add(1,0,0, 1,1,0,16); add(0,0,0, 1,0,0,16); add(1,0,0, 1,0,0,16); add(1,0,0, 1,0,0,16);
        add(1,0,0, 0,0,0,16); add(1,0,0, 0,0,0,16); add(1,0,0, 0,0,0,16); add(1,0,0, 0,0,0,16);
        add(1,0,0, 1,1,0,17);
        // stop exactly on the wrap cycle
        add(1,0,0, 1,0,0,17); add(1,0,0, 1,0,0,17); add(1,0,0, 1,0,0,17);
        add(1,0,0, 0,0,0,17); add(1,0,0, 0,0,0,17); add(1,0,0, 0,0,0,17); add(1,0,0, 0,0,0,17);
        add(0,0,0, 0,0,0,17); add(0,0,0, 0,0,0,17);
        // DIV_IN=1 loaded while idle, applied next edge, runs as N=2
        add(0,1,1, 0,0,1,17); add(0,0,0, 0,0,0,17);
        add(1,0,0, 1,1,0,18); add(1,0,0, 0,0,0,18); add(1,0,0, 1,1,0,19); add(1,0,0, 0,0,0,19);
        // DIV_IN=0 loaded while running, also runs as N=2
        add(1,1,0, 1,1,1,20); add(1,0,0, 0,0,1,20);
        add(1,0,0, 1,1,0,21); add(1,0,0, 0,0,0,21); add(1,0,0, 1,1,0,22);
    endtask

    initial begin
        logic exp_after_rst [6];
        logic exp_tick_rst  [6];

        rst      = 1'b1;
        enable   = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        fill_table();

        step();
        step();
        chk("reset out",   32'(clock_out),  32'd0);
        chk("reset tick",  32'(tick),       32'd0);
        chk("reset busy",  32'(div_busy),   32'd0);
        chk("reset count", 32'(tick_count), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            enable   = vecs[i].en;
            div_load = vecs[i].ld;
            div_in   = vecs[i].din;
            step();
            chk($sformatf("vec%0d out",   i), 32'(clock_out),  32'(vecs[i].out));
            chk($sformatf("vec%0d tick",  i), 32'(tick),       32'(vecs[i].tk));
            chk($sformatf("vec%0d busy",  i), 32'(div_busy),   32'(vecs[i].busy));
            chk($sformatf("vec%0d count", i), 32'(tick_count), 32'(vecs[i].cnt));
        end
        div_load = 1'b0;

        // Async reset during a high phase with a ratio pending
        enable = 1'b1;
        step();
        chk("pre-rst low", 32'(clock_out), 32'd0);
        div_load = 1'b1;
        div_in   = 8'd6;
        step();
        div_load = 1'b0;
        chk("pre-rst high", 32'(clock_out), 32'd1);
        chk("pre-rst busy", 32'(div_busy),  32'd1);
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        chk("async rst out",   32'(clock_out),  32'd0);
        chk("async rst tick",  32'(tick),       32'd0);
        chk("async rst busy",  32'(div_busy),   32'd0);
        chk("async rst count", 32'(tick_count), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post-rst idle", 32'(clock_out), 32'd0);

        exp_after_rst = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_tick_rst  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("post-rst out%0d",  k), 32'(clock_out), 32'(exp_after_rst[k]));
            chk($sformatf("post-rst tick%0d", k), 32'(tick),      32'(exp_tick_rst[k]));
        end
        chk("post-rst count", 32'(tick_count), 32'd2);

        // TICK_COUNT rollover at all-ones, run at N=2 to get there quickly
        div_load = 1'b1;
        div_in   = 8'd2;
        step();
        div_load = 1'b0;
        for (int k = 0; k < 1000 && tick_count != 8'hFF; k++) begin
            step();
        end
        chk("count reaches max", 32'(tick_count), 32'hFF);
        step();
        for (int k = 0; k < 8 && !tick; k++) begin
            step();
        end
        chk("wrap tick seen", 32'(tick),       32'd1);
        chk("count wraps",    32'(tick_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
